// File: rtl/hazard_control_unit.sv
// Load-use stall and branch flush controller for a five-stage pipeline.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic [1:0] hz_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, next_state;
  logic [2:0] flush_cnt, next_cnt;
  logic       load_use;

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state   = RUN;
    next_cnt     = 3'd0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    hz_state     = state;
    if (!rst_n) begin
      // Reset cycles present RUN outputs regardless of the held state.
      hz_state = RUN;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_cnt    = FLUSH_LOAD;
      next_state  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            next_state   = STALL;
          end
        end
        STALL: next_state = RUN;
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          next_cnt    = flush_cnt - 3'd1;
          next_state  = (flush_cnt > 3'd1) ? FLUSH : RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (id_ex_bubble && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (branch_taken && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  // Counter width only matters when the statistics are built in.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (FLUSH_CYCLES=2, CNT_W=4).
// Statistics checks are compiled in when HAZARD_STATS_EN is defined.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       id_ex_mem_read, branch_taken;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
  logic [1:0] hz_state;
`ifdef HAZARD_STATS_EN
  logic [3:0] stall_count, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, hz_state}
  localparam logic [6:0] RUNV    = 7'b11000_00;
  localparam logic [6:0] STALLIN = 7'b00100_00;
  localparam logic [6:0] STALLST = 7'b11000_01;
  localparam logic [6:0] BRR     = 7'b11011_00;
  localparam logic [6:0] BRS     = 7'b11011_01;
  localparam logic [6:0] FL      = 7'b11011_10;

  logic [6:0] outs;
  assign outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, hz_state};

  hazard_control_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .branch_taken   (branch_taken),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .hz_state       (hz_state)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after an edge; outputs are sampled mid-cycle.
  task automatic step(input string tag, input logic [6:0] exp);
    #4;
    chk(tag, {1'b0, outs}, {1'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0;
    id_ex_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(posedge clk); #1;
    step("rst_hold", RUNV);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    step("rst_lu_masked", RUNV);

    rst_n = 1'b1; clear_in();
    step("idle", RUNV);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    step("lu_rs", STALLIN);
    step("stall_one_cycle", STALLST);
    step("lu_again", STALLIN);
    clear_in();
    step("stall_cleared", STALLST);
    step("run_after_stall", RUNV);
    id_ex_mem_read = 1'b1;
    step("rt_zero", RUNV);
    id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7;
    step("lu_rt", STALLIN);
    id_ex_mem_read = 1'b0;
    step("stall_rt", STALLST);
    step("no_mem_read", RUNV);

    clear_in(); branch_taken = 1'b1;
    step("br_run", BRR);
    branch_taken = 1'b0;
    step("flush_cycle2", FL);
    step("flush_done", RUNV);

    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; branch_taken = 1'b1;
    step("br_over_lu", BRR);
    step("br_in_flush", FL);
    branch_taken = 1'b0;
    step("flush_extended", FL);
    id_ex_mem_read = 1'b0;
    step("flush_ext_done", RUNV);

    id_ex_mem_read = 1'b1;
    step("lu_before_br", STALLIN);
    id_ex_mem_read = 1'b0; branch_taken = 1'b1;
    step("br_in_stall", BRS);
    branch_taken = 1'b0;
    step("flush_from_stall", FL);
    step("run_after_flush", RUNV);

    branch_taken = 1'b1;
    step("br_pre_rst", BRR);
    branch_taken = 1'b0; rst_n = 1'b0;
    step("rst_in_flush", RUNV);
    rst_n = 1'b1;
    step("post_rst", RUNV);

`ifdef HAZARD_STATS_EN
    chk("cnt_after_rst", {stall_count, flush_count}, 8'h00);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
    end
    clear_in();
    #4;
    chk("stall_sat", {4'h0, stall_count}, 8'h0f);
    for (int i = 0; i < 3; i++) begin
      branch_taken = 1'b1;
      @(posedge clk); #1;
      branch_taken = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    #4;
    chk("flush_cnt3", {4'h0, flush_count}, 8'h03);
    chk("stall_hold", {4'h0, stall_count}, 8'h0f);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: total cycles the flush outputs stay asserted per taken branch; legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 if_id_rs  input  5  rs field of the instruction in the IF/ID stage.
REQ-006 if_id_rt  input  5  rt field of the instruction in the IF/ID stage.
REQ-007 id_ex_mem_read  input  1  mem_read control currently held in the ID/EX register.
REQ-008 id_ex_rt  input  5  rt (load destination) currently held in the ID/EX register.
REQ-009 branch_taken  input  1  one-cycle pulse: branch resolved taken, PC redirected this cycle.
REQ-010 pc_write  output  1  PC update enable.
REQ-011 if_id_write  output  1  IF/ID register load enable.
REQ-012 id_ex_bubble  output  1  forces all ID/EX control bits to zero on the next edge.
REQ-013 if_id_flush  output  1  clears the IF/ID register on the next edge.
REQ-014 id_ex_flush  output  1  clears the ID/EX register on the next edge.
REQ-015 hz_state  output  2  current FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-016 stall_count, flush_count  output  CNT_W each  statistics counters (present only with HAZARD_STATS_EN).

Function
REQ-017 load_use = id_ex_mem_read AND id_ex_rt != 0 AND (id_ex_rt == if_id_rs OR id_ex_rt == if_id_rt); combinational, zero latency.
REQ-018 In RUN with load_use and no branch_taken: pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle; next state STALL.
REQ-019 STALL lasts exactly one cycle: pc_write=1, if_id_write=1, id_ex_bubble=0; next state RUN, even if load_use is still true.
REQ-020 branch_taken has priority over load_use in every state: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0 in that same cycle.
REQ-021 If FLUSH_CYCLES > 1, branch_taken loads a 3-bit down-counter with FLUSH_CYCLES-1 and enters FLUSH; if FLUSH_CYCLES == 1, the FSM goes to RUN.
REQ-022 In FLUSH: flush outputs asserted, load_use ignored, counter decrements each cycle; at counter==1 next state RUN.
REQ-023 branch_taken while in FLUSH reloads the counter to FLUSH_CYCLES-1 and stays in FLUSH.
REQ-024 In RUN with neither event: pc_write=1, if_id_write=1, all other controls 0.
REQ-025 Encoding 11 is illegal; if reached, the FSM goes to RUN on the next edge with RUN outputs.

Reset
REQ-026 While rst_n=0 at a rising edge: state RUN, flush counter 0, statistics counters 0.
REQ-027 During reset cycles, outputs take RUN values (pc_write=1, if_id_write=1, others 0, hz_state=00).
REQ-028 Reset asserted mid-STALL or mid-FLUSH aborts the state; the first post-reset cycle is RUN.

Configuration
REQ-029 Macro HAZARD_STATS_EN defined: stall_count increments once per cycle with id_ex_bubble=1; flush_count increments once per branch_taken pulse; both saturate at all-ones.
REQ-030 HAZARD_STATS_EN undefined: stall_count, flush_count and their logic are absent; all other behaviour is identical.

Verification
REQ-031 id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 in RUN -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle hz_state=01 with pc_write=1; then RUN.
REQ-032 id_ex_mem_read=1, id_ex_rt=0, if_id_rs=0 -> no stall; pc_write stays 1.
REQ-033 FLUSH_CYCLES=2, one-cycle branch_taken -> if_id_flush and id_ex_flush high for exactly 2 cycles, then RUN.
REQ-034 branch_taken and load_use in the same cycle -> flush outputs 1, id_ex_bubble=0, pc_write=1; a second branch_taken in FLUSH extends the flush by FLUSH_CYCLES-1 cycles.
REQ-035 rst_n=0 for one edge during FLUSH -> next cycle hz_state=00, flush outputs 0, counters 0.
REQ-036 HAZARD_STATS_EN, CNT_W=4, 20 stall events -> stall_count reaches 15 and holds; 3 branches -> flush_count=3.
